ssd_capture: RTL and testbench

Receive-side counterpart of the four-digit seven-segment scan multiplexer. It samples the multiplexed anode-select bus (`ctl`) and segment bus (`ssd_out`) and waits for each scan slot to settle. It then rebuilds the four digit patterns and decodes them to hex. Used for loopback self-check of the display path and for mirroring the display onto a second board.

---
 rtl/ssd_capture_if.sv | 23 ++
 rtl/ssd_capture.sv | 168 ++++++++++++++++
 tb/tb_ssd_capture.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ssd_capture_if.sv
// Signal bundle between a seven-segment scan source and the capture block.
// The master drives the scanned buses; the slave returns the rebuilt frame.
interface ssd_capture_if;
    logic [3:0]  ctl;
    logic [7:0]  ssd_out;
    logic [31:0] digits;
    logic [15:0] hex;
    logic [3:0]  hex_ok;
    logic [3:0]  dp;
    logic        frame_done;
    logic        stale;
    logic        err_ctl;

    modport master (
        output ctl, ssd_out,
        input  digits, hex, hex_ok, dp, frame_done, stale, err_ctl
    );

    modport slave (
        input  ctl, ssd_out,
        output digits, hex, hex_ok, dp, frame_done, stale, err_ctl
    );
endinterface

// File: rtl/ssd_capture.sv
// Rebuilds the four digits of a multiplexed seven-segment display from its
// anode-select and segment buses, decoding each settled slot to hex.
module ssd_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic          clk,
    input  logic          rst,
    ssd_capture_if.slave  bus
);
    // state   | meaning
    // IDLE    | no frame in progress, stale asserted
    // COLLECT | at least one legal slot captured, seen accumulating
    typedef enum logic {IDLE, COLLECT} state_t;

    localparam logic [7:0]  STABLE_C  = 8'(STABLE_CYCLES);
    localparam logic [7:0]  STABLE_M1 = 8'(STABLE_CYCLES - 1);
    localparam logic [23:0] TOUT_M1   = 24'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [11:0] smp_q, smp_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [23:0] tout_q, tout_d;
    logic [3:0]  seen_q, seen_d;
    logic [31:0] digits_q, digits_d;
    logic [15:0] hex_q, hex_d;
    logic [3:0]  hex_ok_q, hex_ok_d;
    logic [3:0]  dp_q, dp_d;
    logic        frame_done_q, frame_done_d;
    logic        stale_q, stale_d;
    logic        err_ctl_q, err_ctl_d;

    logic [11:0] in_w;
    logic        same;
    logic        capture;
    logic        legal;
    logic        blank;
    logic [1:0]  pos;
    logic [4:0]  dec;
    logic        legal_cap;

    // Returns {match, nibble}; unmatched patterns decode to nibble 0.
    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'b0000001: r = {1'b1, 4'h0};
            7'b1001111: r = {1'b1, 4'h1};
            7'b0010010: r = {1'b1, 4'h2};
            7'b0000110: r = {1'b1, 4'h3};
            7'b1001100: r = {1'b1, 4'h4};
            7'b0100100: r = {1'b1, 4'h5};
            7'b0100000: r = {1'b1, 4'h6};
            7'b0001111: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0000100: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b1100000: r = {1'b1, 4'hB};
            7'b0110001: r = {1'b1, 4'hC};
            7'b1000010: r = {1'b1, 4'hD};
            7'b0110000: r = {1'b1, 4'hE};
            7'b0111000: r = {1'b1, 4'hF};
            default:    r = 5'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        in_w    = {bus.ctl, bus.ssd_out};
        same    = (in_w == smp_q);
        capture = same && (cnt_q == STABLE_M1);
        dec     = seg_decode(bus.ssd_out[7:1]);

        legal = 1'b0;
        blank = 1'b0;
        pos   = 2'd0;
        case (bus.ctl)
            4'b1110: begin legal = 1'b1; pos = 2'd0; end
            4'b1101: begin legal = 1'b1; pos = 2'd1; end
            4'b1011: begin legal = 1'b1; pos = 2'd2; end
            4'b0111: begin legal = 1'b1; pos = 2'd3; end
            4'b1111: blank = 1'b1;
            default: ;
        endcase
        legal_cap = capture && legal;

        smp_d        = in_w;
        cnt_d        = 8'd0;
        state_d      = state_q;
        tout_d       = tout_q;
        seen_d       = seen_q;
        digits_d     = digits_q;
        hex_d        = hex_q;
        hex_ok_d     = hex_ok_q;
        dp_d         = dp_q;
        frame_done_d = 1'b0;
        stale_d      = stale_q;
        err_ctl_d    = capture && !legal && !blank;

        if (same) begin
            cnt_d = (cnt_q == STABLE_C) ? cnt_q : cnt_q + 8'd1;
        end

        if (state_q == COLLECT) begin
            if (seen_q == 4'b1111) begin
                frame_done_d = 1'b1;
                seen_d       = 4'b0000;
            end
            // A capture on the timeout edge cancels the timeout entirely.
            if (tout_q == TOUT_M1 && !legal_cap) begin
                state_d = IDLE;
                stale_d = 1'b1;
                seen_d  = 4'b0000;
                tout_d  = 24'd0;
            end else begin
                tout_d = tout_q + 24'd1;
            end
        end

        if (legal_cap) begin
            digits_d[{pos, 3'b000} +: 8] = bus.ssd_out;
            hex_d[{pos, 2'b00} +: 4]     = dec[3:0];
            hex_ok_d[pos]                = dec[4];
            dp_d[pos]                    = ~bus.ssd_out[0];
            seen_d[pos]                  = 1'b1;
            tout_d                       = 24'd0;
            state_d                      = COLLECT;
            stale_d                      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            smp_q        <= 12'hFFF;
            cnt_q        <= 8'd0;
            tout_q       <= 24'd0;
            seen_q       <= 4'b0000;
            digits_q     <= 32'hFFFF_FFFF;
            hex_q        <= 16'h0000;
            hex_ok_q     <= 4'b0000;
            dp_q         <= 4'b0000;
            frame_done_q <= 1'b0;
            stale_q      <= 1'b1;
            err_ctl_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            smp_q        <= smp_d;
            cnt_q        <= cnt_d;
            tout_q       <= tout_d;
            seen_q       <= seen_d;
            digits_q     <= digits_d;
            hex_q        <= hex_d;
            hex_ok_q     <= hex_ok_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
            stale_q      <= stale_d;
            err_ctl_q    <= err_ctl_d;
        end
    end

    assign bus.digits     = digits_q;
    assign bus.hex        = hex_q;
    assign bus.hex_ok     = hex_ok_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = frame_done_q;
    assign bus.stale      = stale_q;
    assign bus.err_ctl    = err_ctl_q;
endmodule

// File: tb/tb_ssd_capture.sv
// Directed bench for ssd_capture: full frame, glitch, illegal/blank select,
// bad pattern, timeout and mid-frame reset, checked with immediate assertions.
module tb_ssd_capture;
    logic clk = 1'b0;
    logic rst;
    int   n_run  = 0;
    int   n_fail = 0;
    int   fd_cnt = 0;
    int   err_cnt = 0;
    int   fd0;
    int   e0;

    ssd_capture_if sif ();

    ssd_capture #(
        .STABLE_CYCLES (4),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif)
    );

    always #5 clk = ~clk;

    // Pulses are counted from the value held just before each rising edge.
    always @(posedge clk) begin
        if (sif.frame_done === 1'b1) fd_cnt++;
        if (sif.err_ctl === 1'b1) err_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [7:0] s);
        sif.ctl     = c;
        sif.ssd_out = s;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(4'hF, 8'hFF);
        cyc(3);
        chk("rst_digits", sif.digits, 32'hFFFF_FFFF);
        chk("rst_hex", {16'h0, sif.hex}, 32'h0);
        chk("rst_hex_ok", {28'h0, sif.hex_ok}, 32'h0);
        chk("rst_dp", {28'h0, sif.dp}, 32'h0);
        chk("rst_frame_done", {31'h0, sif.frame_done}, 32'h0);
        chk("rst_err_ctl", {31'h0, sif.err_ctl}, 32'h0);
        chk("rst_stale", {31'h0, sif.stale}, 32'h1);
        rst = 1'b0;
        cyc(10);
        chk("blank_idle_stale", {31'h0, sif.stale}, 32'h1);

        // full frame
        fd0 = fd_cnt;
        drive(4'hE, 8'h9F);
        cyc(4);
        chk("pre_capture_hex_ok", {28'h0, sif.hex_ok}, 32'h0);
        chk("pre_capture_stale", {31'h0, sif.stale}, 32'h1);
        cyc(1);
        chk("cap0_digits", sif.digits, 32'hFFFF_FF9F);
        chk("cap0_stale", {31'h0, sif.stale}, 32'h0);
        cyc(3);
        drive(4'hD, 8'h25); cyc(8);
        drive(4'hB, 8'h0D); cyc(8);
        drive(4'h7, 8'h99);
        cyc(5);
        chk("frame_digits", sif.digits, 32'h990D_259F);
        chk("fd_not_yet", {31'h0, sif.frame_done}, 32'h0);
        cyc(1);
        chk("fd_pulse", {31'h0, sif.frame_done}, 32'h1);
        cyc(1);
        chk("fd_one_cycle", {31'h0, sif.frame_done}, 32'h0);
        cyc(1);
        chk("frame_hex", {16'h0, sif.hex}, 32'h4321);
        chk("frame_hex_ok", {28'h0, sif.hex_ok}, 32'hF);
        chk("frame_dp", {28'h0, sif.dp}, 32'h0);
        chk("frame_fd_count", fd_cnt - fd0, 32'd1);

        // glitch rejection
        drive(4'hE, 8'h03); cyc(3);
        chk("glitch_pre", {24'h0, sif.digits[7:0]}, 32'h9F);
        drive(4'hE, 8'h02); cyc(1);
        drive(4'hE, 8'h03); cyc(4);
        chk("glitch_resettle", {24'h0, sif.digits[7:0]}, 32'h9F);
        cyc(1);
        chk("glitch_cap_digit", {24'h0, sif.digits[7:0]}, 32'h03);
        chk("glitch_cap_hex", {28'h0, sif.hex[3:0]}, 32'h0);
        chk("glitch_cap_ok", {31'h0, sif.hex_ok[0]}, 32'h1);
        chk("glitch_cap_dp", {31'h0, sif.dp[0]}, 32'h0);
        cyc(5);

        // illegal then blank select
        e0 = err_cnt;
        drive(4'h9, 8'h00); cyc(5);
        chk("illegal_err_pulse", {31'h0, sif.err_ctl}, 32'h1);
        cyc(1);
        chk("illegal_err_clear", {31'h0, sif.err_ctl}, 32'h0);
        chk("illegal_no_write", sif.digits, 32'h990D_2503);
        drive(4'hF, 8'h00); cyc(6);
        chk("blank_err_count", err_cnt - e0, 32'd1);
        chk("blank_no_write", sif.digits, 32'h990D_2503);
        chk("blank_hex", {16'h0, sif.hex}, 32'h4320);

        // bad pattern with decimal point
        drive(4'hB, 8'hFE); cyc(5);
        chk("bad_digit", {24'h0, sif.digits[23:16]}, 32'hFE);
        chk("bad_hex", {16'h0, sif.hex}, 32'h4020);
        chk("bad_hex_ok", {28'h0, sif.hex_ok}, 32'hB);
        chk("bad_dp", {28'h0, sif.dp}, 32'h4);
        cyc(3);

        // timeout
        drive(4'hE, 8'h9F); cyc(5);
        drive(4'hF, 8'hFF); cyc(49);
        chk("tout_before", {31'h0, sif.stale}, 32'h0);
        cyc(1);
        chk("tout_stale", {31'h0, sif.stale}, 32'h1);
        fd0 = fd_cnt;
        drive(4'hD, 8'h25); cyc(8);
        drive(4'hB, 8'h0D); cyc(8);
        drive(4'h7, 8'h99); cyc(8);
        chk("tout_no_fd", fd_cnt - fd0, 32'd0);
        chk("tout_burst_stale", {31'h0, sif.stale}, 32'h0);
        chk("tout_burst_hex", {16'h0, sif.hex}, 32'h4321);

        // reset mid-frame
        drive(4'hF, 8'hFF); cyc(60);
        chk("idle_again_stale", {31'h0, sif.stale}, 32'h1);
        drive(4'hE, 8'h9F); cyc(8);
        drive(4'hD, 8'h25); cyc(8);
        fd0 = fd_cnt;
        #2;
        rst = 1'b1;
        drive(4'hF, 8'hFF);
        #1;
        chk("mid_rst_digits", sif.digits, 32'hFFFF_FFFF);
        chk("mid_rst_stale", {31'h0, sif.stale}, 32'h1);
        chk("mid_rst_hex", {16'h0, sif.hex}, 32'h0);
        chk("mid_rst_hex_ok", {28'h0, sif.hex_ok}, 32'h0);
        cyc(1);
        rst = 1'b0;
        drive(4'h7, 8'h99); cyc(8);
        drive(4'hB, 8'h0D); cyc(8);
        drive(4'hD, 8'h25); cyc(8);
        chk("post_rst_no_early_fd", fd_cnt - fd0, 32'd0);
        drive(4'hE, 8'h9F); cyc(8);
        chk("post_rst_fd_count", fd_cnt - fd0, 32'd1);
        chk("post_rst_digits", sif.digits, 32'h990D_259F);
        chk("post_rst_hex", {16'h0, sif.hex}, 32'h4321);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
